// File: rtl/schoolbook_modred_p521.sv
// Digit-serial reduction of a 1042-bit product modulo the Mersenne prime p = 2^521-1.
// The fold (lo + hi) and the end-around wrap (s + e) share one W-bit adder and one shift register.
module schoolbook_modred_p521 #(
  parameter int W = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1041:0] c,
  output logic [520:0]  r,
  output logic          busy,
  output logic          done
);

  localparam int N  = (521 + W - 1) / W;
  localparam int NW = N * W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] LAST    = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [NW-1:0] ONE     = NW'(1);
  localparam logic [NW-1:0] MASK    = (ONE << 521) - ONE;

  typedef enum logic [1:0] {IDLE, FOLD, WRAP, FIN} state_t;

  state_t          state_q, state_d;
  logic [NW-1:0]   lo_q, lo_d;
  logic [NW-1:0]   hi_q, hi_d;
  logic            carry_q, carry_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [520:0]    r_q, r_d;
  logic            done_q, done_d;

  logic [W:0]      digit;
  logic [NW-1:0]   digit_ext;
  logic [NW-1:0]   lo_shift;
  logic [NW:0]     full;
  logic            last;

  // lo_q doubles as the result register: each sum digit enters at the top while
  // the consumed operand digit leaves at the bottom, so after N steps it holds the sum.
  always_comb begin
    digit     = {1'b0, lo_q[W-1:0]} + {1'b0, hi_q[W-1:0]} + {{W{1'b0}}, carry_q};
    digit_ext = '0;
    digit_ext[W-1:0] = digit[W-1:0];
    lo_shift  = (lo_q >> W) | (digit_ext << (NW - W));
    full      = {digit[W], lo_shift};
    last      = (cnt_q == LAST);
  end

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first, so no path can infer a latch.
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          lo_d           = '0;
          lo_d[520:0]    = c[520:0];
          hi_d           = '0;
          hi_d[520:0]    = c[1041:521];
          carry_d        = 1'b0;
          cnt_d          = '0;
          state_d        = FOLD;
        end
      end
      FOLD: begin
        lo_d    = lo_shift;
        hi_d    = hi_q >> W;
        carry_d = digit[W];
        cnt_d   = cnt_q + CNT_ONE;
        if (last) begin
          // Sum bits above 521 are always zero, so OR-ing them yields exactly bit 521 (e).
          lo_d    = lo_shift & MASK;
          hi_d    = '0;
          carry_d = |(full >> 521);
          cnt_d   = '0;
          state_d = WRAP;
        end
      end
      WRAP: begin
        lo_d    = lo_shift;
        hi_d    = hi_q >> W;
        carry_d = digit[W];
        cnt_d   = cnt_q + CNT_ONE;
        if (last) begin
          lo_d    = lo_shift & MASK;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = FIN;
        end
      end
      FIN: begin
        // t can equal p itself; its canonical residue is zero.
        r_d     = (&lo_q[520:0]) ? '0 : lo_q[520:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      done_q  <= done_d;
    end
  end

  assign r    = r_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: doc/schoolbook_modred_p521.md
SCHOOLBOOK_MODRED_P521 -- requirements
Module: schoolbook_modred_p521

Interface
REQ-001 Parameter: W, 64, adder digit width in bits; legal range 1..521.
REQ-002 Derived constant: N = ceil(521/W), digits per 521-bit operand; W=64 gives N=9.
REQ-003 Port: clk  input  1  rising-edge clock, single clock domain.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: start  input  1  request strobe; sampled only in IDLE.
REQ-006 Port: c  input  1042  product from the 521x521 schoolbook multiplier; sampled on the accepting edge only.
REQ-007 Port: r  output  521  registered result, c mod p, p = 2^521-1.
REQ-008 Port: busy  output  1  high while a reduction is in progress.
REQ-009 Port: done  output  1  one-cycle pulse; r is valid from this cycle.

Function
REQ-010 States: IDLE, FOLD, WRAP, FIN.
- IDLE: start=1 at an edge latches lo=c[520:0], hi=c[1041:521], clears the digit counter and carry, and moves to FOLD.
- start=0 stays in IDLE.
REQ-011 FOLD: one W-bit digit per edge, LSB first.
- Computes s = lo + hi with a registered carry.
- Top digit is partial when 521 is not a multiple of W; only bits 520:0 are meaningful.
- After digit N-1, the carry-out is stored as e = s[521] and the state moves to WRAP.
REQ-012 WRAP: one digit per edge.
- Computes t = s[520:0] + e, with e injected as carry-in to digit 0 only.
- Moves to FIN after digit N-1.
- t <= 2^521-1 by construction; any carry-out is discarded and never set.
REQ-013 FIN: single edge.
- r <= 0 if t == 2^521-1, else r <= t.
- done <= 1; state returns to IDLE.
REQ-014 Latency: start sampled at edge k -> done high in the cycle following edge k+2N+1. Fixed and data-independent: 19 edges at W=64, 3 at W=521.
REQ-015 busy is high from the cycle after the accepting edge through the cycle after the FIN edge exclusive; busy is low whenever done is high.
REQ-016 done is high for exactly one cycle per accepted request; it is never asserted otherwise.
REQ-017 r holds its value from one done until the next FIN edge; it does not change during FOLD/WRAP.
REQ-018 start while busy is ignored: no restart, no queueing, c not resampled.
REQ-019 start high in the same cycle as done (state IDLE) is accepted normally; back-to-back throughput is one result per 2N+2 cycles.
REQ-020 Every 1042-bit c is accepted, including values above (2^521-1)^2; the output is always the canonical residue in [0, p-1].
REQ-021 Arithmetic is unsigned throughout; no X is propagated from unused top-digit bits.

Reset
REQ-022 rst=1 asynchronously forces: state=IDLE, r=0, busy=0, done=0, carry/e=0, digit counter=0, operand registers=0.
REQ-023 rst asserted mid-FOLD/WRAP/FIN aborts the operation: no done pulse, r=0. After release, the block accepts a new start on the first edge.
REQ-024 start is ignored while rst=1.

Verification
REQ-025 c=0 -> done after 19 edges (W=64), r=0.
REQ-026 c=2^1042-1 -> r=0, exercising e=1 and the all-ones correction; c=2^521-1 -> r=0; c=2^521 -> r=1; c=12345 -> r=12345.
REQ-027 start pulsed again on edges k+3 and k+10 after acceptance at k -> single done at k+19, r matches the first c.
REQ-028 rst asserted at edge k+7 of a run with c=2^600 -> no done pulse, r=0; a new start with c=2^600 after release -> r=2^79.
REQ-029 start held high continuously with a new random c each accepted edge -> done every 20 cycles, each r equal to the golden c mod (2^521-1).
REQ-030 Parameter sweep W in {1, 64, 100, 521}, 1000 random c each (including products a*b with a,b < p) -> r matches the golden model, latency 2N+1.
